// File: rtl/tcore_param.sv
// Shared types, cause codes and the exception-to-mcause mapping for the trap path.
package tcore_param;

  localparam int unsigned XLEN = 32;

  typedef enum logic [2:0] {
    NO_EXCEPTION,
    INSTR_MISALIGNED,
    ILLEGAL_INSTR,
    BREAKPOINT,
    LOAD_MISALIGNED,
    STORE_MISALIGNED,
    ECALL_M
  } exc_type_e;

  typedef enum logic [2:0] {
    INSTR_ALU,
    INSTR_LOAD,
    INSTR_STORE,
    INSTR_BRANCH,
    INSTR_MRET
  } instr_type_e;

  typedef enum logic [1:0] {
    StIdle,
    StDrain,
    StCommit,
    StRedirect
  } trap_state_e;

  localparam logic [XLEN-1:0] CAUSE_INSTR_MISALIGNED = 32'd0;
  localparam logic [XLEN-1:0] CAUSE_ILLEGAL_INSTR    = 32'd2;
  localparam logic [XLEN-1:0] CAUSE_BREAKPOINT       = 32'd3;
  localparam logic [XLEN-1:0] CAUSE_LOAD_MISALIGNED  = 32'd4;
  localparam logic [XLEN-1:0] CAUSE_STORE_MISALIGNED = 32'd6;
  localparam logic [XLEN-1:0] CAUSE_ECALL_M          = 32'd11;
  localparam logic [XLEN-1:0] CAUSE_IRQ_M_EXT        = 32'h8000_000B;

  // Synchronous exception type to mcause value.
  function automatic logic [XLEN-1:0] exc_cause(input exc_type_e exc);
    logic [XLEN-1:0] cause;
    case (exc)
      INSTR_MISALIGNED: cause = CAUSE_INSTR_MISALIGNED;
      ILLEGAL_INSTR:    cause = CAUSE_ILLEGAL_INSTR;
      BREAKPOINT:       cause = CAUSE_BREAKPOINT;
      LOAD_MISALIGNED:  cause = CAUSE_LOAD_MISALIGNED;
      STORE_MISALIGNED: cause = CAUSE_STORE_MISALIGNED;
      ECALL_M:          cause = CAUSE_ECALL_M;
      default:          cause = '0;
    endcase
    return cause;
  endfunction

endpackage

// File: rtl/trap_controller.sv
// Machine-mode trap sequencer: accepts one exception/interrupt from IDLE, drains a busy
// execute stage, strobes the mepc/mcause update, then redirects fetch to mtvec.
module trap_controller
  import tcore_param::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  exc_type_e         exc_type_i,
  input  logic [XLEN-1:0]   exc_pc_i,
  input  instr_type_e       instr_type_i,
  input  logic              irq_i,
  input  logic              mie_i,
  input  logic              ex_stall_i,
  input  logic [XLEN-1:0]   mtvec_i,
  output logic              trap_active_o,
  output logic [XLEN-1:0]   trap_cause_o,
  output logic [XLEN-1:0]   trap_mepc_o,
  output logic              flush_o,
  output logic              stall_o,
  output logic              redirect_o,
  output logic [XLEN-1:0]   redirect_pc_o
);

  trap_state_e     state_q, state_d;
  logic [XLEN-1:0] cause_q, cause_d;
  logic [XLEN-1:0] mepc_q, mepc_d;
  logic            exc_pending;
  logic            irq_pending;

  // Only direct-mode vectoring is supported, so the mode bits are dropped.
  logic unused_mtvec_mode;
  assign unused_mtvec_mode = ^mtvec_i[1:0];

  // An mret in execute masks the interrupt so the return itself is not trapped.
  assign exc_pending = (exc_type_i != NO_EXCEPTION);
  assign irq_pending = irq_i && mie_i && (instr_type_i != INSTR_MRET);

  // State and trap record registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cause_q <= '0;
      mepc_q  <= '0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      mepc_q  <= mepc_d;
    end
  end

  // Next-state logic; events are only sampled in IDLE, exceptions beat interrupts.
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    mepc_d  = mepc_q;
    unique case (state_q)
      StIdle: begin
        if (exc_pending || irq_pending) begin
          cause_d = exc_pending ? exc_cause(exc_type_i) : CAUSE_IRQ_M_EXT;
          mepc_d  = exc_pc_i;
          state_d = ex_stall_i ? StDrain : StCommit;
        end
      end
      StDrain: begin
        if (!ex_stall_i) begin
          state_d = StCommit;
        end
      end
      StCommit:   state_d = StRedirect;
      StRedirect: state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  // Outputs decode straight from state so reset clears them without waiting for a clock.
  always_comb begin
    trap_active_o = (state_q == StCommit);
    redirect_o    = (state_q == StRedirect);
    flush_o       = (state_q != StIdle);
    stall_o       = (state_q != StIdle);
    trap_cause_o  = trap_active_o ? cause_q : '0;
    trap_mepc_o   = trap_active_o ? mepc_q : '0;
    redirect_pc_o = redirect_o ? {mtvec_i[XLEN-1:2], 2'b00} : '0;
  end

endmodule
